ahblite_sram_slave: RTL and testbench
=====================================

Name: ahblite_sram_slave

Overview:
AHB-Lite subordinate that sits directly downstream of ahblite_interconnect: it consumes one slave port (slv_* outputs) and returns HREADYOUT/HRDATA/HRESP/HEXOKAY to it. It implements a flop-based word memory with a configurable wait-state count and two-cycle ERROR responses. It also contains a single-entry exclusive-access monitor, so the interconnect's HEXCL/HEXOKAY path can be exercised end to end.

Parameters:
HADDR_WIDTH, 32, address width
HDATA_WIDTH, 32, data width; 32 or 64 only
MEM_DEPTH, 256, number of HDATA_WIDTH words
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; range 0..15

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select, from address decode
HTRANS  in  2  transfer type
HBURST  in  3  burst type; ignored apart from pipelining
HSIZE  in  3  transfer size
HWRITE  in  1  1 = write
HADDR  in  HADDR_WIDTH  byte address
HWDATA  in  HDATA_WIDTH  write data, valid in data phase
HMASTLOCK  in  1  ignored
HPROT  in  7  ignored
HNONSEC  in  1  ignored
HEXCL  in  1  exclusive transfer
HMASTER  in  4  master ID, used by the exclusive monitor
HREADY  in  1  bus ready, from interconnect
HREADYOUT  out  1  slave ready
HRDATA  out  HDATA_WIDTH  read data
HRESP  out  1  0 = OKAY, 1 = ERROR
HEXOKAY  out  1  exclusive write success

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous and active-low.
- Reset values: HREADYOUT=1, HRESP=0, HEXOKAY=0, HRDATA=0, state=IDLE, monitor invalid, all memory words 0.
- Reset mid-transfer: all outputs go to reset values immediately and any pending write is dropped.
- Address-phase accept: HSEL & HREADY & HTRANS[1] at a rising edge. Captured into registers: word index, HADDR low bits, HSIZE, HWRITE, HEXCL, HMASTER.
- IDLE/BUSY or unselected cycles: zero-wait OKAY, nothing captured.
- Error check, done at accept time:
  - word index >= MEM_DEPTH, or
  - HADDR not aligned to HSIZE, or
  - (1<<HSIZE) > HDATA_WIDTH/8.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, counter decrements. Go to DATA when count reaches 0.
  - DATA: HREADYOUT=1, OKAY.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions on accept, evaluated from IDLE, DATA or ERR2 (pipelined back-to-back transfers allowed):
  - error -> ERR1.
  - WAIT_STATES=0 -> DATA.
  - otherwise -> WAIT, counter loaded with WAIT_STATES-1.
  - no accept -> IDLE.
  - ERR1 -> ERR2 unconditionally.
- Error transfers skip wait states. Latency: OKAY = WAIT_STATES+1 data-phase cycles; ERROR = 2.
- Write commit: at the end of the DATA cycle. Byte lanes are little-endian, selected by HSIZE and the captured addr[2:0].
- Read data: HRDATA = mem[captured index] combinationally in a read DATA cycle, otherwise 0. A read issued directly after a write to the same word returns the new data; no forwarding is needed.
- Exclusive monitor (one entry: valid, master ID, word index):
  - Exclusive read with OKAY response: loads the entry with HMASTER and the index.
  - Exclusive write, entry matches master and index: write performed, HEXOKAY=1 in the DATA cycle, entry cleared.
  - Exclusive write, no match: write suppressed, HEXOKAY=0, HRESP=OKAY.
  - Non-exclusive write by any master to the monitored index: clears the entry.
  - Errored transfers never touch the monitor.
  - Exclusive read and write both to the same index in one cycle cannot occur; reads only load at DATA.

Decomposition:
- Shared package ahblite_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - HBURST encodings (SINGLE, INCR, WRAP4, INCR4, ...);
  - HSIZE encodings (BYTE/HALFWORD/WORD/DWORD);
  - HRESP_OKAY and HRESP_ERROR;
  - slave state enum.
- One sub-module, ahblite_excl_monitor, holds the entry and produces set/clear/match.

Test Plan:
- WAIT_STATES=0: write WORD 0xDEADBEEF @0x10, then read @0x10 back-to-back -> HREADYOUT stays 1, HRDATA=0xDEADBEEF in the second data cycle.
- WAIT_STATES=2: read @0x4 -> HREADYOUT 0,0,1 over the data phase, HRESP=0.
- BYTE writes 0x11 @0x20 and 0x22 @0x23 -> word read @0x20 returns 0x22000011.
- Read @0x1000 (MEM_DEPTH=256), then HALFWORD @0x1 -> each gives HRESP=1 for 2 cycles with HREADYOUT 0 then 1; memory unchanged.
- Monitor, master 3: exclusive read @0x40, then exclusive write 0xA5 -> HEXOKAY=1, memory=0xA5. Repeat the exclusive write -> HEXOKAY=0, memory unchanged.
- Assert HRESETn=0 while in WAIT during a write -> HREADYOUT=1 immediately, the write does not land, memory reads 0.

Source files
------------

// File: rtl/ahblite_pkg.sv
// rtl/ahblite_pkg.sv - shared AHB-Lite encodings, slave state type and size helper
package ahblite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_BYTE     = 3'b000;
    localparam logic [2:0] HSIZE_HALFWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD     = 3'b010;
    localparam logic [2:0] HSIZE_DWORD    = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    function automatic logic [7:0] hsize_bytes(input logic [2:0] hsize);
        return 8'd1 << hsize;
    endfunction

endpackage

// File: rtl/ahblite_excl_monitor.sv
// rtl/ahblite_excl_monitor.sv - single-entry exclusive-access monitor (master ID + word index)
module ahblite_excl_monitor #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             excl_wr_i,
    input  logic             plain_wr_i,
    input  logic [3:0]       master_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             match_o
);

    logic             valid_q, valid_d;
    logic [3:0]       master_q, master_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             idx_hit;
    logic             set;
    logic             clr;

    assign idx_hit = valid_q && (idx_q == idx_i);
    assign match_o = idx_hit && (master_q == master_i);
    assign set     = load_i;
    // A successful exclusive write consumes the reservation; any plain write to it breaks it.
    assign clr     = (excl_wr_i && match_o) || (plain_wr_i && idx_hit);

    always_comb begin
        valid_d  = valid_q;
        master_d = master_q;
        idx_d    = idx_q;
        if (set) begin
            valid_d  = 1'b1;
            master_d = master_i;
            idx_d    = idx_i;
        end else if (clr) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            master_q <= '0;
            idx_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            master_q <= master_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: rtl/ahblite_sram_slave.sv
// rtl/ahblite_sram_slave.sv - AHB-Lite flop-memory subordinate with wait states, ERROR and exclusive monitor
module ahblite_sram_slave
    import ahblite_pkg::*;
#(
    parameter int HADDR_WIDTH = 32,
    parameter int HDATA_WIDTH = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HSEL,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic [2:0]             HSIZE,
    input  logic                   HWRITE,
    input  logic [HADDR_WIDTH-1:0] HADDR,
    input  logic [HDATA_WIDTH-1:0] HWDATA,
    input  logic                   HMASTLOCK,
    input  logic [6:0]             HPROT,
    input  logic                   HNONSEC,
    input  logic                   HEXCL,
    input  logic [3:0]             HMASTER,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic [HDATA_WIDTH-1:0] HRDATA,
    output logic                   HRESP,
    output logic                   HEXOKAY
);

    localparam int         BYTES     = HDATA_WIDTH / 8;
    localparam int         OFF_W     = $clog2(BYTES);
    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       addr_lo_q, addr_lo_d;
    logic [2:0]       size_q, size_d;
    logic             write_q, write_d;
    logic             excl_q, excl_d;
    logic [3:0]       master_q, master_d;
    logic             hreadyout_q, hreadyout_d;
    logic             hresp_q, hresp_d;

    logic [HDATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [HDATA_WIDTH-1:0] mem_word_d;

    logic                   can_accept;
    logic                   accept;
    logic [HADDR_WIDTH-1:0] word_addr;
    logic [7:0]             req_bytes;
    logic                   addr_err;
    logic                   rd_cyc;
    logic                   wr_cyc;
    logic                   excl_match;
    logic                   mem_we;
    logic                   unused_ok;

    assign unused_ok = ^{HBURST, HMASTLOCK, HPROT, HNONSEC, HTRANS[0]};

    // Pipelined accept: a new address phase may land in the last data cycle of the previous one.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign accept     = HSEL && HREADY && HTRANS[1] && can_accept;
    assign word_addr  = HADDR >> OFF_W;
    assign req_bytes  = hsize_bytes(HSIZE);
    assign addr_err   = (word_addr >= HADDR_WIDTH'(MEM_DEPTH))
                     || ((HADDR[2:0] & 3'(req_bytes - 8'd1)) != 3'd0)
                     || (req_bytes > 8'(BYTES));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        addr_lo_d = addr_lo_q;
        size_d    = size_q;
        write_d   = write_q;
        excl_d    = excl_q;
        master_d  = master_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (accept) begin
                    idx_d     = word_addr[IDX_W-1:0];
                    addr_lo_d = HADDR[2:0];
                    size_d    = HSIZE;
                    write_d   = HWRITE;
                    excl_d    = HEXCL;
                    master_d  = HMASTER;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            addr_lo_q   <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            excl_q      <= 1'b0;
            master_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            write_q     <= write_d;
            excl_q      <= excl_d;
            master_q    <= master_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign rd_cyc = (state_q == ST_DATA) && !write_q;
    assign wr_cyc = (state_q == ST_DATA) && write_q;
    assign mem_we = wr_cyc && (!excl_q || excl_match);

    // Little-endian lane merge; the captured size is already known to be aligned and in range.
    always_comb begin
        int off;
        int nbytes;
        off        = int'(addr_lo_q) % BYTES;
        nbytes     = int'(hsize_bytes(size_q));
        mem_word_d = mem_q[idx_q];
        for (int i = 0; i < BYTES; i++) begin
            if ((i >= off) && (i < off + nbytes)) begin
                mem_word_d[i*8 +: 8] = HWDATA[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= mem_word_d;
        end
    end

    ahblite_excl_monitor #(
        .IDX_W(IDX_W)
    ) u_excl_mon (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .load_i     (rd_cyc && excl_q),
        .excl_wr_i  (wr_cyc && excl_q),
        .plain_wr_i (wr_cyc && !excl_q),
        .master_i   (master_q),
        .idx_i      (idx_q),
        .match_o    (excl_match)
    );

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = rd_cyc ? mem_q[idx_q] : '0;
    assign HEXOKAY   = wr_cyc && excl_q && excl_match;

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// tb/tb_ahblite_sram_slave.sv - directed self-checking bench for ahblite_sram_slave
module tb_ahblite_sram_slave;

    logic        clk;
    logic        hresetn;
    logic        hsel;
    logic        tgt_ws2;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hmastlock;
    logic [6:0]  hprot;
    logic        hnonsec;
    logic        hexcl;
    logic [3:0]  hmaster;

    logic        ro0, rp0, ek0, ro2, rp2, ek2;
    logic [31:0] rd0, rd2;
    logic        hreadyout, hresp, hexokay;
    logic [31:0] hrdata;

    int n_checks;
    int n_errors;

    assign hreadyout = tgt_ws2 ? ro2 : ro0;
    assign hresp     = tgt_ws2 ? rp2 : rp0;
    assign hexokay   = tgt_ws2 ? ek2 : ek0;
    assign hrdata    = tgt_ws2 ? rd2 : rd0;

    ahblite_sram_slave #(
        .HADDR_WIDTH(32), .HDATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)
    ) u_dut0 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel && !tgt_ws2), .HTRANS(htrans),
        .HBURST(hburst), .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
        .HMASTLOCK(hmastlock), .HPROT(hprot), .HNONSEC(hnonsec), .HEXCL(hexcl),
        .HMASTER(hmaster), .HREADY(ro0), .HREADYOUT(ro0), .HRDATA(rd0), .HRESP(rp0),
        .HEXOKAY(ek0)
    );

    ahblite_sram_slave #(
        .HADDR_WIDTH(32), .HDATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)
    ) u_dut2 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel && tgt_ws2), .HTRANS(htrans),
        .HBURST(hburst), .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
        .HMASTLOCK(hmastlock), .HPROT(hprot), .HNONSEC(hnonsec), .HEXCL(hexcl),
        .HMASTER(hmaster), .HREADY(ro2), .HREADYOUT(ro2), .HRDATA(rd2), .HRESP(rp2),
        .HEXOKAY(ek2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic ws2, input logic wr, input logic ex, input logic [3:0] mst,
                        input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                        output logic [7:0] rdy_seq, output logic [7:0] resp_seq,
                        output logic [31:0] rdata, output logic exok, output int ncyc);
        logic done;
        @(posedge clk); #1;
        tgt_ws2 = ws2; hsel = 1'b1; htrans = 2'b10; hwrite = wr; hexcl = ex;
        hmaster = mst; haddr = addr; hsize = size;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hexcl = 1'b0; hwdata = wdata;
        rdy_seq = '0; resp_seq = '0; rdata = '0; exok = 1'b0; ncyc = 0; done = 1'b0;
        while (!done && ncyc < 16) begin
            @(negedge clk);
            rdy_seq  = {rdy_seq[6:0], hreadyout};
            resp_seq = {resp_seq[6:0], hresp};
            rdata    = hrdata;
            exok     = hexokay;
            ncyc++;
            if (hreadyout) done = 1'b1;
            else @(posedge clk);
        end
        check("xfer_done", done, 1);
    endtask

    logic [7:0]  rdy, rsp;
    logic [31:0] rdat;
    logic        eok;
    int          nc;

    initial begin
        n_checks = 0; n_errors = 0;
        hresetn = 1'b0; hsel = 1'b0; tgt_ws2 = 1'b0; htrans = 2'b00; hburst = 3'b000;
        hsize = 3'b010; hwrite = 1'b0; haddr = '0; hwdata = '0; hmastlock = 1'b0;
        hprot = '0; hnonsec = 1'b0; hexcl = 1'b0; hmaster = '0;
        #12;
        check("rst_hreadyout0", ro0, 1);
        check("rst_hresp0", rp0, 0);
        check("rst_hexokay0", ek0, 0);
        check("rst_hrdata0", rd0, 0);
        check("rst_hreadyout2", ro2, 1);
        @(posedge clk); #1 hresetn = 1'b1;

        // back-to-back write then read, zero wait states
        @(posedge clk); #1;
        tgt_ws2 = 1'b0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'b010;
        @(posedge clk); #1;
        hwdata = 32'hDEADBEEF; hwrite = 1'b0;
        @(negedge clk);
        check("b2b_wr_ready", hreadyout, 1);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check("b2b_rd_ready", hreadyout, 1);
        check("b2b_rd_data", hrdata, 32'hDEADBEEF);

        // two wait states on the second instance
        xfer(1, 0, 0, 0, 32'h4, 3'b010, 0, rdy, rsp, rdat, eok, nc);
        check("ws2_ready_seq", rdy, 8'b001);
        check("ws2_resp_seq", rsp, 8'b000);
        check("ws2_cycles", nc, 3);

        // byte lanes
        xfer(0, 1, 0, 0, 32'h20, 3'b000, 32'h00000011, rdy, rsp, rdat, eok, nc);
        xfer(0, 1, 0, 0, 32'h23, 3'b000, 32'h22000000, rdy, rsp, rdat, eok, nc);
        xfer(0, 0, 0, 0, 32'h20, 3'b010, 0, rdy, rsp, rdat, eok, nc);
        check("byte_merge", rdat, 32'h22000011);

        // out-of-range and misaligned transfers
        xfer(0, 0, 0, 0, 32'h1000, 3'b010, 0, rdy, rsp, rdat, eok, nc);
        check("oor_ready_seq", rdy, 8'b01);
        check("oor_resp_seq", rsp, 8'b11);
        check("oor_rdata", rdat, 0);
        xfer(0, 1, 0, 0, 32'h1, 3'b001, 32'hFFFFFFFF, rdy, rsp, rdat, eok, nc);
        check("misalign_ready_seq", rdy, 8'b01);
        check("misalign_resp_seq", rsp, 8'b11);
        xfer(0, 0, 0, 0, 32'h0, 3'b010, 0, rdy, rsp, rdat, eok, nc);
        check("misalign_mem_unchanged", rdat, 0);

        // exclusive monitor, master 3
        xfer(0, 0, 1, 3, 32'h40, 3'b010, 0, rdy, rsp, rdat, eok, nc);
        xfer(0, 1, 1, 3, 32'h40, 3'b010, 32'hA5, rdy, rsp, rdat, eok, nc);
        check("excl_ok", eok, 1);
        xfer(0, 0, 0, 3, 32'h40, 3'b010, 0, rdy, rsp, rdat, eok, nc);
        check("excl_mem", rdat, 32'hA5);
        xfer(0, 1, 1, 3, 32'h40, 3'b010, 32'h5A, rdy, rsp, rdat, eok, nc);
        check("excl_repeat_fail", eok, 0);
        check("excl_repeat_resp", rsp, 8'b0);
        xfer(0, 0, 0, 3, 32'h40, 3'b010, 0, rdy, rsp, rdat, eok, nc);
        check("excl_repeat_mem", rdat, 32'hA5);

        // plain write by another master breaks the reservation
        xfer(0, 0, 1, 3, 32'h40, 3'b010, 0, rdy, rsp, rdat, eok, nc);
        xfer(0, 1, 0, 1, 32'h40, 3'b010, 32'h77, rdy, rsp, rdat, eok, nc);
        xfer(0, 1, 1, 3, 32'h40, 3'b010, 32'h99, rdy, rsp, rdat, eok, nc);
        check("excl_broken", eok, 0);
        xfer(0, 0, 0, 3, 32'h40, 3'b010, 0, rdy, rsp, rdat, eok, nc);
        check("excl_broken_mem", rdat, 32'h77);

        // reset while a write sits in wait states
        @(posedge clk); #1;
        tgt_ws2 = 1'b1; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h12345678;
        @(negedge clk);
        check("rstw_in_wait", hreadyout, 0);
        #2 hresetn = 1'b0;
        #1;
        check("rstw_ready_async", hreadyout, 1);
        check("rstw_resp", hresp, 0);
        @(posedge clk); #1 hresetn = 1'b1;
        xfer(1, 0, 0, 0, 32'h8, 3'b010, 0, rdy, rsp, rdat, eok, nc);
        check("rstw_mem_zero", rdat, 0);
        check("rstw_read_ready_seq", rdy, 8'b001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
